// File: rtl/video_timing_gen.sv
// ZX Spectrum style video timing generator: 14 MHz in, 7/3.5 MHz enables,
// raster counters, syncs, region flags and the Z80 frame interrupt.
module video_timing_gen #(
  parameter int HW      = 9,
  parameter int VW      = 9,
  parameter int INT_LEN = 64
) (
  input  logic          clk14m,
  input  logic          rst_,
  input  logic [1:0]    mode,
  output logic          ce7,
  output logic          ce35,
  output logic [HW-1:0] hcnt,
  output logic [VW-1:0] vcnt,
  output logic          hsync_,
  output logic          vsync_,
  output logic          int_,
  output logic          blank,
  output logic          border,
  output logic          paper,
  output logic          line_start,
  output logic          frame_start
);

  localparam int IW = (INT_LEN > 1) ? $clog2(INT_LEN) : 1;

  typedef enum logic [1:0] {
    MODE_PENT = 2'd0,
    MODE_128  = 2'd1,
    MODE_48   = 2'd2
  } mode_e;

  mode_e         mode_q;
  logic [1:0]    div;
  logic [HW-1:0] hpos;
  logic [VW-1:0] vpos;
  logic [IW-1:0] int_cnt;

  logic [HW-1:0] h_last, int_h, h_nxt;
  logic [VW-1:0] v_last, int_v, v_nxt;
  logic          tick, h_wrap, v_wrap, int_hit;
  logic          paper_nxt, blank_nxt, hsync_nxt, vsync_nxt;

  assign hcnt = hpos;
  assign vcnt = vpos;
  assign tick = ce7;

  always_comb begin : mode_table
    h_last = HW'(447);
    v_last = VW'(319);
    int_v  = VW'(239);
    int_h  = HW'(320);
    case (mode_q)
      MODE_128: begin
        h_last = HW'(455);
        v_last = VW'(310);
        int_v  = VW'(248);
        int_h  = '0;
      end
      MODE_48: begin
        h_last = HW'(447);
        v_last = VW'(311);
        int_v  = VW'(248);
        int_h  = '0;
      end
      default: ;
    endcase
  end

  assign h_wrap = (hpos == h_last);
  assign v_wrap = (vpos == v_last);

  always_comb begin : next_position
    h_nxt = hpos;
    v_nxt = vpos;
    if (tick) begin
      if (h_wrap) begin
        h_nxt = '0;
        v_nxt = v_wrap ? '0 : vpos + 1'b1;
      end else begin
        h_nxt = hpos + 1'b1;
      end
    end
  end

  // Flags decode the next position so they line up with the registered counters.
  always_comb begin : region_decode
    paper_nxt = (h_nxt < HW'(256)) && (v_nxt < VW'(192));
    blank_nxt = ((h_nxt >= HW'(320)) && (h_nxt <= HW'(383))) ||
                ((v_nxt >= VW'(240)) && (v_nxt <= VW'(255)));
    hsync_nxt = !((h_nxt >= HW'(336)) && (h_nxt <= HW'(367)));
    vsync_nxt = !((v_nxt >= VW'(240)) && (v_nxt <= VW'(243)));
  end

  assign int_hit = tick && (h_nxt == int_h) && (v_nxt == int_v);

  always_ff @(posedge clk14m or negedge rst_) begin
    if (!rst_) begin
      div         <= 2'd0;
      ce7         <= 1'b0;
      ce35        <= 1'b0;
      hpos        <= '0;
      vpos        <= '0;
      mode_q      <= MODE_PENT;
      int_cnt     <= '0;
      int_        <= 1'b1;
      hsync_      <= 1'b1;
      vsync_      <= 1'b1;
      paper       <= 1'b1;
      blank       <= 1'b0;
      border      <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      div         <= div + 2'd1;
      ce7         <= ~div[0];
      ce35        <= (div == 2'd2);
      hpos        <= h_nxt;
      vpos        <= v_nxt;
      line_start  <= tick && h_wrap;
      frame_start <= tick && h_wrap && v_wrap;
      paper       <= paper_nxt;
      blank       <= blank_nxt;
      border      <= !paper_nxt && !blank_nxt;
      hsync_      <= hsync_nxt;
      vsync_      <= vsync_nxt;

      // New timing takes effect only at the frame boundary; mode 3 folds to Pentagon.
      if (tick && h_wrap && v_wrap)
        mode_q <= (mode == 2'd3) ? MODE_PENT : mode_e'(mode);

      // A trigger seen while the pulse is already low is ignored.
      if (!int_) begin
        if (tick) begin
          if (int_cnt == IW'(INT_LEN - 1)) begin
            int_    <= 1'b1;
            int_cnt <= '0;
          end else begin
            int_cnt <= int_cnt + 1'b1;
          end
        end
      end else if (int_hit) begin
        int_    <= 1'b0;
        int_cnt <= '0;
      end
    end
  end

endmodule

// File: doc/video_timing_gen.md
VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 Parameter HW, default 9: horizontal counter width in bits.
REQ-002 Parameter VW, default 9: vertical counter width in bits.
REQ-003 Parameter INT_LEN, default 64: int_ low duration in 7 MHz ticks (32 Z80 T-states).
REQ-004 Port clk14m, input, 1 bit: sole clock, 14 MHz, all state on rising edge.
REQ-005 Port rst_, input, 1 bit: reset, asynchronous assert, active-low; deassertion is synchronous to clk14m.
REQ-006 Port mode, input, 2 bits: timing select; 0 Pentagon, 1 128K, 2 48K, 3 treated as Pentagon.
REQ-007 Port ce7, output, 1 bit: 7 MHz pixel clock enable, one clk14m cycle wide.
REQ-008 Port ce35, output, 1 bit: 3.5 MHz CPU clock enable, one clk14m cycle wide.
REQ-009 Ports hcnt (HW bits) and vcnt (VW bits), outputs: current pixel column and line.
REQ-010 Ports hsync_, vsync_, int_, outputs, 1 bit each: active-low sync and Z80 interrupt.
REQ-011 Ports blank, border, paper, outputs, 1 bit each: region flags, exactly one high at any time.
REQ-012 Ports line_start and frame_start, outputs, 1 bit each: single-cycle strobes.

Function
REQ-013 2-bit divider div increments every clk14m; ce7 = (div[0]==1); ce35 = (div==3).
REQ-014 hcnt advances only on ce7; at H_TOTAL-1 it wraps to 0 and vcnt advances; vcnt wraps to 0 after V_TOTAL-1.
REQ-015 Mode table (H_TOTAL, V_TOTAL, INT_V, INT_H): Pentagon 448, 320, 239, 320; 128K 456, 311, 248, 0; 48K 448, 312, 248, 0.
REQ-016 Active mode mode_q is loaded from mode only on the ce7 tick where hcnt==H_TOTAL-1 and vcnt==V_TOTAL-1; mode changes mid-frame have no effect until then.
REQ-017 paper = hcnt<256 and vcnt<192.
REQ-018 blank = (hcnt in 320..383) or (vcnt in 240..255); border = neither paper nor blank.
REQ-019 hsync_ low for hcnt 336..367 inclusive; vsync_ low for vcnt 240..243 inclusive.
REQ-020 int_ goes low on the ce7 tick where counters reach (INT_V, INT_H) and stays low exactly INT_LEN ce7 ticks, independent of line wrap.
REQ-021 A new int_ trigger while int_ is already low restarts nothing; pulse length is unaffected.
REQ-022 line_start high for one clk14m cycle on the ce7 tick where hcnt becomes 0; frame_start likewise when hcnt and vcnt both become 0.
REQ-023 All outputs are registered; flags and syncs are valid in the same cycle as the hcnt/vcnt values they decode.
REQ-024 Counter widths: HW must hold H_TOTAL-1 and VW must hold V_TOTAL-1 for every mode; wrap comparisons use full width, no truncation.

Reset
REQ-025 While rst_ is low: div=0, hcnt=0, vcnt=0, mode_q=0 (Pentagon), int counter=0, ce7=0, ce35=0.
REQ-026 While rst_ is low: hsync_=1, vsync_=1, int_=1, paper=1, blank=0, border=0, line_start=0, frame_start=0.
REQ-027 Reset asserted mid-frame or mid int_ pulse clears everything immediately; counting resumes from 0,0 on the second clk14m edge after release.

Verification
REQ-028 Reset release, mode=0 -> ce7 every 2nd clk14m, ce35 every 4th; first ce35 coincides with a ce7.
REQ-029 mode=0, run one frame -> line_start every 448 ce7 ticks; frame_start every 143360 ce7 ticks; hsync_ low 32 ticks per line.
REQ-030 mode=1 from reset, after first frame boundary -> 456x311 frame, 141816 ce7 ticks per frame.
REQ-031 Pentagon, INT_LEN=64 -> int_ falls at vcnt=239 hcnt=320, rises at vcnt=239 hcnt=384, once per frame.
REQ-032 Change mode 0->2 at vcnt=100 -> current frame remains 320 lines; next frame is 312 lines, int_ at vcnt=248 hcnt=0.
REQ-033 Assert rst_ low during int_ pulse at vcnt=239 -> int_=1, hcnt=0, vcnt=0 at once; normal frame follows release.
